// File: rtl/transmitter_buffer.sv
// transmitter_buffer: byte FIFO plus transmit sequencer feeding the UART
// transmitter data synchronizer. Narrow pushes store one byte. Wide pushes
// store two bytes, low byte first. Each byte is issued with a one-cycle valid
// pulse. The next byte waits until the transmitter busy bit has risen and
// fallen again.
// Optional feature macro: TRANSMITTER_BUFFER_TIMEOUT_EN enables the busy-rise
// timeout. Without it, WAIT_HIGH waits indefinitely and handshake_timeout is 0.
`timescale 1ns/1ps

module transmitter_buffer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write_enable,
  input  logic                          write_wide,
  input  logic [2*DATA_WIDTH-1:0]       write_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  input  logic                          transmitter_busy_synchronized,
  output logic                          transmitter_parallel_data_valid,
  output logic [DATA_WIDTH-1:0]         transmitter_parallel_data,
  output logic                          handshake_timeout
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  // Reject illegal configurations at elaboration
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("transmitter_buffer: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES in 1..255");
  end

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      free_slots;
  logic [CNT_W-1:0]      need_slots;
  logic [CNT_W-1:0]      fill_next;
  logic                  push_ok;
  logic                  pop;
  logic                  timeout_hit;

  // Push admission: free slots are judged before any same-cycle pop
  always_comb begin
    need_slots = write_wide ? CNT_W'(2) : CNT_W'(1);
    free_slots = CNT_W'(FIFO_DEPTH) - fill_level;
    push_ok    = write_enable && (free_slots >= need_slots);
    pop        = (state == ISSUE);
    fill_next  = fill_level + (push_ok ? need_slots : '0) - CNT_W'(pop);
  end

  // Storage array: contents need no reset, the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= write_data[DATA_WIDTH-1:0];
      if (write_wide) begin
        mem[wr_ptr + PTR_W'(1)] <= write_data[2*DATA_WIDTH-1:DATA_WIDTH];
      end
    end
  end

`ifdef TRANSMITTER_BUFFER_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Count cycles spent waiting for busy to rise; cleared while issuing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt          <= '0;
      handshake_timeout <= 1'b0;
    end else begin
      handshake_timeout <= timeout_hit;
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT_HIGH) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end
`else
  assign handshake_timeout = 1'b0;
`endif

  // Next-state logic for the transmit sequencer
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !transmitter_busy_synchronized) state_next = ISSUE;
      end
      ISSUE: begin
        state_next = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (transmitter_busy_synchronized) begin
          state_next = WAIT_LOW;
        end
`ifdef TRANSMITTER_BUFFER_TIMEOUT_EN
        else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      WAIT_LOW: begin
        if (!transmitter_busy_synchronized) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointers, fill level and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                           <= IDLE;
      wr_ptr                          <= '0;
      rd_ptr                          <= '0;
      fill_level                      <= '0;
      empty                           <= 1'b1;
      full                            <= 1'b0;
      overflow                        <= 1'b0;
      transmitter_parallel_data_valid <= 1'b0;
      transmitter_parallel_data       <= '0;
    end else begin
      state                           <= state_next;
      fill_level                      <= fill_next;
      empty                           <= (fill_next == '0);
      full                            <= (fill_next == CNT_W'(FIFO_DEPTH));
      overflow                        <= write_enable && !push_ok;
      transmitter_parallel_data_valid <= pop;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(need_slots);
      end
      if (pop) begin
        rd_ptr                    <= rd_ptr + PTR_W'(1);
        transmitter_parallel_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_transmitter_buffer.sv
// Scoreboard bench for transmitter_buffer. Stimulus queues the expected bytes.
// A negedge monitor pops and compares them on each valid pulse. It also checks
// pulse spacing and that the data stays stable between issues.
`timescale 1ns/1ps

module tb_transmitter_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable;
  logic        write_wide;
  logic [15:0] write_data;
  logic        full;
  logic        empty;
  logic [3:0]  fill_level;
  logic        overflow;
  logic        busy;
  logic        valid;
  logic [7:0]  data;
  logic        handshake_timeout;

  int          total = 0;
  int          bad = 0;
  int          valid_count = 0;
  logic [7:0]  sb [$];
  logic [7:0]  last_data = 8'h00;
  bit          prev_valid = 1'b0;
  bit          need_busy = 1'b0;
  bit          busy_auto = 1'b0;
  logic        busy_val = 1'b0;
  int          hold = 3;
  int          bcnt = 0;

  transmitter_buffer #(
    .DATA_WIDTH     (8),
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk                             (clk),
    .reset                           (reset),
    .write_enable                    (write_enable),
    .write_wide                      (write_wide),
    .write_data                      (write_data),
    .full                            (full),
    .empty                           (empty),
    .fill_level                      (fill_level),
    .overflow                        (overflow),
    .transmitter_busy_synchronized   (busy),
    .transmitter_parallel_data_valid (valid),
    .transmitter_parallel_data       (data),
    .handshake_timeout               (handshake_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Transmitter model: forced level, or busy for 'hold' cycles starting two cycles after each valid
  initial begin
    busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (busy_auto) begin
        if (valid) bcnt = hold + 2;
        else if (bcnt > 0) bcnt--;
        busy = (bcnt > 0) && (bcnt <= hold);
      end else begin
        bcnt = 0;
        busy = busy_val;
      end
    end
  end

  // Monitor: compares issued bytes with the scoreboard and checks pacing and data hold
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
      need_busy  = 1'b0;
      last_data  = 8'h00;
    end else begin
      if (valid) begin
        check("valid spacing", {30'd0, prev_valid, need_busy}, 32'd0);
        check("byte queued at valid", 32'(sb.size() > 0), 32'd1);
        valid_count++;
        if (sb.size() > 0) check("issued byte", data, sb.pop_front());
        last_data = data;
        need_busy = 1'b1;
      end else begin
        check("data hold", data, last_data);
      end
      prev_valid = valid;
      if (busy || handshake_timeout) need_busy = 1'b0;
    end
  end

  task automatic push(input logic wide, input logic [15:0] d, input logic exp_ok, input string nm);
    write_enable = 1'b1;
    write_wide   = wide;
    write_data   = d;
    @(posedge clk); #1;
    write_enable = 1'b0;
    if (exp_ok) begin
      sb.push_back(d[7:0]);
      if (wide) sb.push_back(d[15:8]);
    end
    check({nm, " overflow"}, overflow, !exp_ok);
  endtask

  task automatic wait_valid(input string nm, input int bound);
    int n = 0;
    while (valid !== 1'b1 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " valid seen"}, valid, 1);
  endtask

  task automatic wait_drain(input string nm, input int bound);
    int n = 0;
    while ((sb.size() != 0 || empty !== 1'b1) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " drained"}, sb.size(), 0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    int n;
    write_enable = 1'b0;
    write_wide   = 1'b0;
    write_data   = 16'h0000;
    #1 reset = 1'b0;
    #20;
    check("rst empty", empty, 1);
    check("rst full", full, 0);
    check("rst fill", fill_level, 0);
    check("rst valid", valid, 0);
    check("rst data", data, 0);
    check("rst overflow", overflow, 0);
    check("rst timeout", handshake_timeout, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // T1: narrow push, two-cycle latency, manual busy handshake
    push(1'b0, 16'h00A5, 1'b1, "t1 push");
    check("t1 fill", fill_level, 1);
    check("t1 not empty", empty, 0);
    @(posedge clk); #1;
    check("t1 latency 1", valid, 0);
    @(posedge clk); #1;
    check("t1 latency 2", valid, 1);
    check("t1 data", data, 8'hA5);
    @(negedge clk) busy_val = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk) busy_val = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t1 empty after", empty, 1);
    check("t1 fill after", fill_level, 0);

    // T2: wide push, low byte then high byte, each after its own busy cycle
    @(negedge clk) busy_auto = 1'b1;
    @(posedge clk); #1;
    push(1'b1, 16'hBEEF, 1'b1, "t2 push");
    check("t2 fill", fill_level, 2);
    wait_drain("t2", 200);

    // T3: seven bytes, wide push rejected, last narrow push fills
    @(negedge clk) begin busy_auto = 1'b0; busy_val = 1'b1; end
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) push(1'b0, 16'(32'h11 + i), 1'b1, "t3 push");
    check("t3 fill 7", fill_level, 7);
    check("t3 not full", full, 0);
    push(1'b1, 16'h2221, 1'b0, "t3 wide reject");
    check("t3 fill kept", fill_level, 7);
    push(1'b0, 16'h0018, 1'b1, "t3 last narrow");
    check("t3 full", full, 1);
    check("t3 fill 8", fill_level, 8);

    // T4: push into a full FIFO during the ISSUE cycle is rejected, pop proceeds
    @(negedge clk) busy_auto = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    push(1'b0, 16'h0019, 1'b0, "t4 push on pop");
    check("t4 pop valid", valid, 1);
    check("t4 pop data", data, 8'h11);
    check("t4 fill", fill_level, 7);
    check("t4 not full", full, 0);
    wait_drain("t4", 400);

    // T5: reset while in WAIT_LOW with three bytes stored
    @(negedge clk) begin busy_auto = 1'b0; busy_val = 1'b1; end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(1'b0, 16'(32'h31 + i), 1'b1, "t5 push");
    check("t5 fill 4", fill_level, 4);
    @(negedge clk) busy_val = 1'b0;
    wait_valid("t5", 20);
    check("t5 fill 3", fill_level, 3);
    @(negedge clk) busy_val = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    check("t5 rst valid", valid, 0);
    check("t5 rst data", data, 0);
    check("t5 rst fill", fill_level, 0);
    check("t5 rst empty", empty, 1);
    check("t5 rst full", full, 0);
    check("t5 rst overflow", overflow, 0);
    check("t5 rst timeout", handshake_timeout, 0);
    sb.delete();
    vc = valid_count;
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    busy_val = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("t5 no valid after reset", valid_count, vc);
    check("t5 empty after reset", empty, 1);

`ifdef TRANSMITTER_BUFFER_TIMEOUT_EN
    // T6: busy never rises, timeout after 255 WAIT_HIGH cycles, next byte follows
    push(1'b1, 16'h4241, 1'b1, "t6 push");
    wait_valid("t6 first", 10);
    n = 0;
    while (handshake_timeout !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6 timeout delay", n, 255);
    @(posedge clk); #1;
    check("t6 timeout pulse width", handshake_timeout, 0);
    wait_valid("t6 second", 20);
    check("t6 fill", fill_level, 0);
`else
    n = 0;
    check("timeout tied low", handshake_timeout, 0);
    check("idle loop count", n, 0);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
